io_pad_mux: RTL

IO_PAD_MUX -- requirements
Module: io_pad_mux

---
 rtl/io_pad_mux_if.sv | 13 +
 rtl/io_pad_mux.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/io_pad_mux_if.sv
// io_pad_mux_if: APB bus bundle (no wait states) connecting a master to io_pad_mux.
interface io_pad_mux_if;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [7:0]  PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;

  modport master (output PSEL, PENABLE, PWRITE, PADDR, PWDATA, input PRDATA, PREADY);
  modport slave  (input PSEL, PENABLE, PWRITE, PADDR, PWDATA, output PRDATA, PREADY);
endinterface

// File: rtl/io_pad_mux.sv
// io_pad_mux: APB-programmable pad function mux with GPIO and synchronized inputs.
// Pad-edge interrupt logic is built only when IO_PAD_MUX_IRQ_EN is defined.
module io_pad_mux #(
  parameter int NPADS = 38,
  parameter int NFUNC = 4
) (
  input  logic                        HCLK,
  input  logic                        HRESETn,
  io_pad_mux_if.slave                 apb,
  input  logic [NPADS-1:0]            pad_in,
  output logic [NPADS-1:0]            pad_out,
  output logic [NPADS-1:0]            pad_oeb,
  input  logic [(NFUNC-1)*NPADS-1:0]  alt_out,
  input  logic [(NFUNC-1)*NPADS-1:0]  alt_oeb,
  output logic [NPADS-1:0]            alt_in,
  output logic                        irq
);

  localparam logic [63:0] PAD_MASK = (NPADS >= 64) ? '1 : ((64'd1 << NPADS) - 64'd1);

  logic         wr_en;
  logic [5:0]   word;
  logic [63:0]  wr_mask, wr_data;
  logic [127:0] sel_q, sel_d;
  logic [63:0]  gpio_out_q, gpio_oe_q;
  logic [NPADS-1:0] sync1_q, sync2_q;
  logic [63:0]  irq_en_q, irq_edge_q, irq_stat_q;
  logic [63:0]  rd_vec;
  logic [31:0]  prdata;
  logic         unused_addr_lsb;

  assign wr_en   = apb.PSEL & apb.PENABLE & apb.PWRITE;
  assign word    = apb.PADDR[7:2];
  assign wr_data = {apb.PWDATA, apb.PWDATA};
  assign wr_mask = (word[0] ? {32'hFFFF_FFFF, 32'h0} : {32'h0, 32'hFFFF_FFFF}) & PAD_MASK;
  assign unused_addr_lsb = ^apb.PADDR[1:0];

  // An out-of-range function code leaves its field untouched; neighbours still update.
  always_comb begin
    sel_d = sel_q;
    if (wr_en && word < 6'd4) begin
      for (int i = 0; i < 16; i++) begin
        if (int'(word) * 16 + i < NPADS && int'(apb.PWDATA[2*i +: 2]) < NFUNC)
          sel_d[(int'(word) * 16 + i) * 2 +: 2] = apb.PWDATA[2*i +: 2];
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      sel_q      <= '0;
      gpio_out_q <= '0;
      gpio_oe_q  <= '0;
    end else begin
      sel_q <= sel_d;
      if (wr_en && word[5:1] == 5'd2) gpio_out_q <= (gpio_out_q & ~wr_mask) | (wr_data & wr_mask);
      if (wr_en && word[5:1] == 5'd3) gpio_oe_q  <= (gpio_oe_q  & ~wr_mask) | (wr_data & wr_mask);
    end
  end

  // p0/p1: two-flop synchronizer for the asynchronous pad inputs
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= pad_in;
      sync2_q <= sync1_q;
    end
  end

`ifdef IO_PAD_MUX_IRQ_EN
  logic [NPADS-1:0] sync3_q;
  logic [63:0]      cur_v, prev_v, edge_set, stat_clr;
  logic             irq_q;

  assign cur_v    = 64'(sync2_q);
  assign prev_v   = 64'(sync3_q);
  assign edge_set = irq_en_q & ((irq_edge_q & cur_v & ~prev_v) | (~irq_edge_q & ~cur_v & prev_v));
  assign stat_clr = (wr_en && word[5:1] == 5'd7) ? (wr_data & wr_mask) : '0;

  // p2: edge history copy, sticky status (set beats a same-cycle clear), registered irq
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      sync3_q    <= '0;
      irq_en_q   <= '0;
      irq_edge_q <= '0;
      irq_stat_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      sync3_q <= sync2_q;
      if (wr_en && word[5:1] == 5'd5) irq_en_q   <= (irq_en_q   & ~wr_mask) | (wr_data & wr_mask);
      if (wr_en && word[5:1] == 5'd6) irq_edge_q <= (irq_edge_q & ~wr_mask) | (wr_data & wr_mask);
      irq_stat_q <= (irq_stat_q & ~stat_clr) | edge_set;
      irq_q      <= |irq_stat_q;
    end
  end

  assign irq = irq_q;
`else
  assign irq_en_q   = '0;
  assign irq_edge_q = '0;
  assign irq_stat_q = '0;
  assign irq        = 1'b0;
`endif

  always_comb begin
    rd_vec = '0;
    prdata = '0;
    if (word < 6'd4) begin
      for (int i = 0; i < 16; i++) begin
        if (int'(word) * 16 + i < NPADS)
          prdata[2*i +: 2] = sel_q[(int'(word) * 16 + i) * 2 +: 2];
      end
    end else begin
      case (word[5:1])
        5'd2:    rd_vec = gpio_out_q;
        5'd3:    rd_vec = gpio_oe_q;
        5'd4:    rd_vec = 64'(sync2_q);
        5'd5:    rd_vec = irq_en_q;
        5'd6:    rd_vec = irq_edge_q;
        5'd7:    rd_vec = irq_stat_q;
        default: rd_vec = '0;
      endcase
      prdata = word[0] ? rd_vec[63:32] : rd_vec[31:0];
    end
    if (!apb.PSEL) prdata = '0;
  end

  assign apb.PRDATA = prdata;
  assign apb.PREADY = 1'b1;

  always_comb begin
    pad_out = '0;
    pad_oeb = '1;
    alt_in  = '1;
    for (int p = 0; p < NPADS; p++) begin
      if (sel_q[2*p +: 2] == 2'd0) begin
        pad_out[p] = gpio_out_q[p];
        pad_oeb[p] = ~gpio_oe_q[p];
      end else if (int'(sel_q[2*p +: 2]) < NFUNC) begin
        pad_out[p] = alt_out[(int'(sel_q[2*p +: 2]) - 1) * NPADS + p];
        pad_oeb[p] = alt_oeb[(int'(sel_q[2*p +: 2]) - 1) * NPADS + p];
        alt_in[p]  = sync2_q[p];
      end
    end
  end

endmodule
